// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: states, opcodes,
// opcode classes and the datapath mux/ALU select codes.
package rv_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_t;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_IALU   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // Bit positions of the one-hot opcode class vector
    localparam int NUM_CLASS  = 9;
    localparam int CLS_RTYPE  = 0;
    localparam int CLS_IALU   = 1;
    localparam int CLS_LOAD   = 2;
    localparam int CLS_STORE  = 3;
    localparam int CLS_BRANCH = 4;
    localparam int CLS_JAL    = 5;
    localparam int CLS_JALR   = 6;
    localparam int CLS_LUI    = 7;
    localparam int CLS_AUIPC  = 8;

    typedef logic [NUM_CLASS-1:0] opclass_t;

    localparam logic [6:0] CLASS_OPCODE [NUM_CLASS] = '{
        OPC_RTYPE, OPC_IALU, OPC_LOAD, OPC_STORE, OPC_BRANCH,
        OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC
    };

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

    localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JALR   = 2'b10;

    localparam logic [1:0] SRCA_PC   = 2'b00;
    localparam logic [1:0] SRCA_RS1  = 2'b01;
    localparam logic [1:0] SRCA_ZERO = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;
    localparam logic [1:0] WB_IMM    = 2'b11;

    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
    localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

endpackage

// File: rtl/rv_opcode_class.sv
// Combinational opcode classifier: one-hot class vector plus an illegal flag
// for anything outside the supported RV32I base opcodes.
module rv_opcode_class
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output opclass_t   cls,
    output logic       illegal
);

    generate
        for (genvar gi = 0; gi < NUM_CLASS; gi++) begin : g_match
            assign cls[gi] = (opcode == CLASS_OPCODE[gi]);
        end
    endgenerate

    assign illegal = ~|cls;

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control FSM: sequences FETCH/DECODE/EXEC/MEM/WB over a
// shared memory port, with memory-wait timeout, illegal-opcode trap and instret.
module multicycle_control_fsm
    import rv_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TO_W           = 8,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    input  logic             mem_ready,
    input  logic             trap_clear,
    output logic             mem_req,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic [1:0]       PCSource,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic             RegWrite,
    output logic [1:0]       WbSel,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [2:0]       state_o
);

    state_t           state_reg, state_next;
    logic [TO_W-1:0]  wait_cnt_reg;
    logic [CNT_W-1:0] instret_reg;
    logic [1:0]       cause_reg, cause_next;

    opclass_t cls;
    logic     illegal;

    rv_opcode_class u_class (
        .opcode  (opcode),
        .cls     (cls),
        .illegal (illegal)
    );

    logic     is_mem_op;
    logic     is_wb_op;
    logic     timeout_hit;
    state_t   boundary_state;

    assign is_mem_op = cls[CLS_LOAD] | cls[CLS_STORE];
    assign is_wb_op  = cls[CLS_RTYPE] | cls[CLS_IALU] | cls[CLS_JAL] | cls[CLS_JALR]
                     | cls[CLS_LUI] | cls[CLS_AUIPC];

    // mem_ready takes priority over the timeout, so only a stalled request can trap
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && mem_req && !mem_ready
                      && (wait_cnt_reg == TO_W'(TIMEOUT_CYCLES));

    assign boundary_state = run ? ST_FETCH : ST_IDLE;

    always_comb begin
        state_next = state_reg;
        cause_next = cause_reg;
        case (state_reg)
            ST_IDLE: begin
                if (run) state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (mem_ready) begin
                    state_next = ST_DECODE;
                end else if (timeout_hit) begin
                    state_next = ST_TRAP;
                    cause_next = TRAP_TIMEOUT;
                end
            end
            ST_DECODE: begin
                if (illegal) begin
                    state_next = ST_TRAP;
                    cause_next = TRAP_ILLEGAL;
                end else begin
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cls[CLS_BRANCH]) begin
                    state_next = boundary_state;
                end else if (is_mem_op) begin
                    state_next = ST_MEM;
                end else if (is_wb_op) begin
                    state_next = ST_WB;
                end else begin
                    state_next = ST_TRAP;
                    cause_next = TRAP_ILLEGAL;
                end
            end
            ST_MEM: begin
                if (mem_ready) begin
                    state_next = cls[CLS_LOAD] ? ST_WB : boundary_state;
                end else if (timeout_hit) begin
                    state_next = ST_TRAP;
                    cause_next = TRAP_TIMEOUT;
                end
            end
            ST_WB: begin
                state_next = boundary_state;
            end
            ST_TRAP: begin
                if (trap_clear) begin
                    state_next = ST_IDLE;
                    cause_next = TRAP_NONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cause_next = TRAP_NONE;
            end
        endcase
    end

    always_comb begin
        mem_req  = 1'b0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        PCSource = PCSRC_PLUS4;
        ALUSrcA  = SRCA_PC;
        ALUSrcB  = SRCB_RS2;
        ALUOp    = ALUOP_ADD;
        RegWrite = 1'b0;
        WbSel    = WB_ALUOUT;
        retire   = 1'b0;
        trap     = 1'b0;
        case (state_reg)
            ST_FETCH: begin
                mem_req = 1'b1;
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                end
            end
            ST_DECODE: begin
                ALUSrcB = SRCB_IMM;
            end
            ST_EXEC: begin
                if (cls[CLS_RTYPE]) begin
                    ALUSrcA = SRCA_RS1;
                    ALUOp   = ALUOP_FUNCT;
                end else if (cls[CLS_IALU]) begin
                    ALUSrcA = SRCA_RS1;
                    ALUSrcB = SRCB_IMM;
                    ALUOp   = ALUOP_FUNCT;
                end else if (is_mem_op) begin
                    ALUSrcA = SRCA_RS1;
                    ALUSrcB = SRCB_IMM;
                end else if (cls[CLS_BRANCH]) begin
                    ALUSrcA  = SRCA_RS1;
                    ALUOp    = ALUOP_BRANCH;
                    PCWrite  = branch_taken;
                    PCSource = PCSRC_ALUOUT;
                    retire   = 1'b1;
                end else if (cls[CLS_JAL]) begin
                    PCWrite  = 1'b1;
                    PCSource = PCSRC_ALUOUT;
                end else if (cls[CLS_JALR]) begin
                    ALUSrcA  = SRCA_RS1;
                    ALUSrcB  = SRCB_IMM;
                    PCWrite  = 1'b1;
                    PCSource = PCSRC_JALR;
                end
            end
            ST_MEM: begin
                mem_req  = 1'b1;
                IorD     = 1'b1;
                MemRead  = cls[CLS_LOAD];
                MemWrite = cls[CLS_STORE];
                retire   = cls[CLS_STORE] & mem_ready;
            end
            ST_WB: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
                if (cls[CLS_LOAD])                      WbSel = WB_MDR;
                else if (cls[CLS_JAL] | cls[CLS_JALR])  WbSel = WB_PC;
                else if (cls[CLS_LUI])                  WbSel = WB_IMM;
            end
            ST_TRAP: begin
                trap = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            wait_cnt_reg <= '0;
            instret_reg  <= '0;
            cause_reg    <= TRAP_NONE;
        end else begin
            state_reg <= state_next;
            cause_reg <= cause_next;
            if (retire) instret_reg <= instret_reg + CNT_W'(1);
            // Restart the wait count on each new memory access; saturate rather than wrap
            if ((state_next == ST_FETCH || state_next == ST_MEM) && state_next != state_reg)
                wait_cnt_reg <= '0;
            else if (mem_req && !mem_ready && wait_cnt_reg != '1)
                wait_cnt_reg <= wait_cnt_reg + TO_W'(1);
        end
    end

    assign instret    = instret_reg;
    assign trap_cause = cause_reg;
    assign state_o    = state_reg;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: per-cycle expected control
// vectors are queued by the driver and compared by a negedge monitor.
module tb_multicycle_control_fsm;

    localparam int CNT_W = 32;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_L     = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_BAD   = 7'b1111111;

    typedef struct packed {
        logic [2:0] st;
        logic       mreq, iord, mrd, mwr, irw, pcw;
        logic [1:0] pcs, asa, asb, aop;
        logic       rw;
        logic [1:0] wbs;
        logic       ret, trp;
        logic [1:0] tc;
    } ctrl_t;

    logic             clk, reset, run, branch_taken, mem_ready, trap_clear;
    logic [6:0]       opcode;
    logic             mem_req, IorD, MemRead, MemWrite, IRWrite, PCWrite, RegWrite;
    logic [1:0]       PCSource, ALUSrcA, ALUSrcB, ALUOp, WbSel, trap_cause;
    logic             retire, trap;
    logic [CNT_W-1:0] instret;
    logic [2:0]       state_o;

    multicycle_control_fsm #(.TIMEOUT_CYCLES(4), .TO_W(8), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .run(run), .opcode(opcode),
        .branch_taken(branch_taken), .mem_ready(mem_ready), .trap_clear(trap_clear),
        .mem_req(mem_req), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSource(PCSource),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .RegWrite(RegWrite), .WbSel(WbSel), .retire(retire), .instret(instret),
        .trap(trap), .trap_cause(trap_cause), .state_o(state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    int    exp_instret = 0;
    ctrl_t exp_q[$];
    string tag_q[$];
    ctrl_t obs_vec;

    assign obs_vec = {state_o, mem_req, IorD, MemRead, MemWrite, IRWrite, PCWrite,
                      PCSource, ALUSrcA, ALUSrcB, ALUOp, RegWrite, WbSel,
                      retire, trap, trap_cause};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        ctrl_t e;
        string t;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, 64'(obs_vec), 64'(e));
        end
    end

    // Queue this cycle's expectation, then advance to just after the next edge
    task automatic step(input string tag, input ctrl_t e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    function automatic ctrl_t f_idle();
        ctrl_t e = '0;
        return e;
    endfunction

    function automatic ctrl_t f_fetch(input logic rdy);
        ctrl_t e = '0;
        e.st = 3'd1; e.mreq = 1'b1; e.mrd = 1'b1; e.asb = 2'b01;
        e.irw = rdy; e.pcw = rdy;
        return e;
    endfunction

    function automatic ctrl_t f_decode();
        ctrl_t e = '0;
        e.st = 3'd2; e.asb = 2'b10;
        return e;
    endfunction

    function automatic ctrl_t f_exec(input logic [6:0] op, input logic taken);
        ctrl_t e = '0;
        e.st = 3'd3;
        case (op)
            OP_R:       begin e.asa = 2'b01; e.asb = 2'b00; e.aop = 2'b10; end
            OP_I:       begin e.asa = 2'b01; e.asb = 2'b10; e.aop = 2'b10; end
            OP_L, OP_S: begin e.asa = 2'b01; e.asb = 2'b10; e.aop = 2'b00; end
            OP_B:       begin e.asa = 2'b01; e.aop = 2'b01; e.pcw = taken; e.pcs = 2'b01; e.ret = 1'b1; end
            OP_JAL:     begin e.pcw = 1'b1; e.pcs = 2'b01; end
            OP_JALR:    begin e.asa = 2'b01; e.asb = 2'b10; e.pcw = 1'b1; e.pcs = 2'b10; end
            default: ;
        endcase
        return e;
    endfunction

    function automatic ctrl_t f_mem(input logic [6:0] op, input logic rdy);
        ctrl_t e = '0;
        e.st = 3'd4; e.mreq = 1'b1; e.iord = 1'b1;
        e.mrd = (op == OP_L); e.mwr = (op == OP_S);
        e.ret = (op == OP_S) && rdy;
        return e;
    endfunction

    function automatic ctrl_t f_wb(input logic [6:0] op);
        ctrl_t e = '0;
        e.st = 3'd5; e.rw = 1'b1; e.ret = 1'b1;
        if (op == OP_L)                          e.wbs = 2'b01;
        else if (op == OP_JAL || op == OP_JALR)  e.wbs = 2'b10;
        else if (op == OP_LUI)                   e.wbs = 2'b11;
        return e;
    endfunction

    function automatic ctrl_t f_trap(input logic [1:0] cause);
        ctrl_t e = '0;
        e.st = 3'd6; e.trp = 1'b1; e.tc = cause;
        return e;
    endfunction

    task automatic do_instr(input string name, input logic [6:0] op, input logic taken,
                            input int fwait, input int mwait);
        int cyc = 0;
        opcode = op;
        branch_taken = taken;
        for (int i = 0; i < fwait; i++) begin
            mem_ready = 1'b0; step({name, ".fetch_wait"}, f_fetch(1'b0)); cyc++;
        end
        mem_ready = 1'b1; step({name, ".fetch"}, f_fetch(1'b1)); cyc++;
        step({name, ".decode"}, f_decode()); cyc++;
        step({name, ".exec"}, f_exec(op, taken)); cyc++;
        if (op == OP_L || op == OP_S) begin
            for (int i = 0; i < mwait; i++) begin
                mem_ready = 1'b0; step({name, ".mem_wait"}, f_mem(op, 1'b0)); cyc++;
            end
            mem_ready = 1'b1; step({name, ".mem"}, f_mem(op, 1'b1)); cyc++;
        end
        if (op != OP_B && op != OP_S) begin
            step({name, ".wb"}, f_wb(op)); cyc++;
        end
        exp_instret++;
        check({name, ".instret"}, 64'(instret), 64'(exp_instret));
        $display("instr %-8s op=%b cycles=%0d instret=%0d", name, op, cyc, instret);
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; opcode = OP_R; branch_taken = 1'b0;
        mem_ready = 1'b1; trap_clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.state", 64'(state_o), 64'd0);
        check("reset.mem_req", 64'(mem_req), 64'd0);
        check("reset.instret", 64'(instret), 64'd0);
        check("reset.trap_cause", 64'(trap_cause), 64'd0);
        reset = 1'b0;
        step("idle.norun0", f_idle());
        step("idle.norun1", f_idle());
        run = 1'b1;
        step("idle.run", f_idle());

        do_instr("add",    OP_R,     1'b0, 0, 0);
        do_instr("lw",     OP_L,     1'b0, 0, 3);
        do_instr("beq_t",  OP_B,     1'b1, 0, 0);
        do_instr("bne_nt", OP_B,     1'b0, 0, 0);
        do_instr("sw",     OP_S,     1'b0, 1, 0);
        do_instr("addi",   OP_I,     1'b0, 2, 0);
        do_instr("jal",    OP_JAL,   1'b0, 0, 0);
        do_instr("jalr",   OP_JALR,  1'b0, 0, 0);
        do_instr("lui",    OP_LUI,   1'b0, 0, 0);
        // run dropped before the instruction starts still lets it complete
        run = 1'b0;
        do_instr("auipc",  OP_AUIPC, 1'b0, 0, 0);
        step("idle.stopped0", f_idle());
        step("idle.stopped1", f_idle());
        run = 1'b1;
        step("idle.restart", f_idle());

        opcode = OP_BAD; mem_ready = 1'b1;
        step("bad.fetch", f_fetch(1'b1));
        step("bad.decode", f_decode());
        step("bad.trap0", f_trap(2'b01));
        step("bad.trap1", f_trap(2'b01));
        trap_clear = 1'b1;
        step("bad.trap_clear", f_trap(2'b01));
        trap_clear = 1'b0;
        check("bad.instret", 64'(instret), 64'(exp_instret));
        $display("instr %-8s op=%b trapped instret=%0d", "illegal", OP_BAD, instret);
        step("bad.idle", f_idle());

        opcode = OP_R; mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) step("to.fetch_wait", f_fetch(1'b0));
        step("to.trap0", f_trap(2'b10));
        trap_clear = 1'b1;
        step("to.trap_clear", f_trap(2'b10));
        trap_clear = 1'b0;
        check("to.instret", 64'(instret), 64'(exp_instret));
        $display("instr %-8s op=%b timed out instret=%0d", "timeout", OP_R, instret);
        step("to.idle", f_idle());
        do_instr("to_edge", OP_R, 1'b0, 4, 0);

        opcode = OP_S; mem_ready = 1'b1;
        step("swrst.fetch", f_fetch(1'b1));
        step("swrst.decode", f_decode());
        step("swrst.exec", f_exec(OP_S, 1'b0));
        mem_ready = 1'b0;
        step("swrst.mem0", f_mem(OP_S, 1'b0));
        check("swrst.pre_mem_req", 64'(mem_req), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        exp_instret = 0;
        check("swrst.mem_req", 64'(mem_req), 64'd0);
        check("swrst.MemWrite", 64'(MemWrite), 64'd0);
        check("swrst.state", 64'(state_o), 64'd0);
        check("swrst.instret", 64'(instret), 64'(exp_instret));
        $display("instr %-8s op=%b reset mid-MEM instret=%0d", "sw_rst", OP_S, instret);
        @(posedge clk);
        #1;
        check("swrst.hold_state", 64'(state_o), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Multi-cycle successor to the single-cycle RV32I control decoder. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB over a shared instruction/data memory port with a ready handshake.
- It adds a memory-wait timeout, an illegal-opcode trap and a retired-instruction counter.
- It sits between the instruction register and the multi-cycle datapath, and drives all datapath enables and mux selects.

Parameters:
- TIMEOUT_CYCLES, 16, max cycles a mem_req may wait for mem_ready before trapping; 0 disables the timeout.
- TO_W, 8, width of the wait counter; TIMEOUT_CYCLES < 2**TO_W.
- CNT_W, 32, width of the instret counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  start/continue execution from IDLE.
- opcode  in  7  instr[6:0] from the instruction register.
- branch_taken  in  1  branch condition from the datapath comparator, valid in EXEC.
- mem_ready  in  1  memory completes the current access this cycle.
- trap_clear  in  1  leave TRAP and return to IDLE.
- mem_req  out  1  memory access request.
- IorD  out  1  0 = PC address, 1 = ALU address.
- MemRead  out  1  read access.
- MemWrite  out  1  write access.
- IRWrite  out  1  load the instruction register.
- PCWrite  out  1  update PC.
- PCSource  out  2  00 = PC+4, 01 = ALUOut (branch/JAL target), 10 = ALU result & ~1 (JALR).
- ALUSrcA  out  2  00 = PC, 01 = rs1, 10 = zero.
- ALUSrcB  out  2  00 = rs2, 01 = const 4, 10 = imm.
- ALUOp  out  2  00 = add, 01 = branch compare, 10 = funct decode.
- RegWrite  out  1  register-file write enable.
- WbSel  out  2  00 = ALUOut, 01 = MDR, 10 = PC (link), 11 = imm (LUI).
- retire  out  1  one-cycle pulse when an instruction completes.
- instret  out  CNT_W  retired-instruction count.
- trap  out  1  high while in TRAP.
- trap_cause  out  2  01 = illegal opcode, 10 = memory timeout.
- state_o  out  3  current state, for debug.

Behaviour:
- Reset: clk is the only clock; reset is asynchronous and active-high. While reset is high, state = IDLE, wait counter = 0, instret = 0 and trap_cause = 00. All outputs are 0 in IDLE.
- Output timing: all control outputs decode combinationally from the registered state plus opcode, mem_ready and branch_taken. Registers update on the rising edge of clk.
- IDLE: if run = 1, go to FETCH.
- FETCH:
  - Drive mem_req = 1, IorD = 0, MemRead = 1, ALUSrcA = 00, ALUSrcB = 01, ALUOp = 00.
  - When mem_ready = 1, drive IRWrite = 1, PCWrite = 1, PCSource = 00, and go to DECODE.
- DECODE:
  - Drive ALUSrcA = 00, ALUSrcB = 10, ALUOp = 00 (precompute PC-relative target; the FETCH PC is held by the datapath's oldPC register).
  - Legal opcodes are 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111. A legal opcode goes to EXEC; anything else goes to TRAP with cause 01.
- EXEC, by opcode class:
  - R-type: ALUSrcA 01, ALUSrcB 00, ALUOp 10, then WB.
  - I-ALU: ALUSrcA 01, ALUSrcB 10, ALUOp 10, then WB.
  - Load/Store: ALUSrcA 01, ALUSrcB 10, ALUOp 00, then MEM.
  - Branch: ALUSrcA 01, ALUSrcB 00, ALUOp 01, PCWrite = branch_taken, PCSource 01; counts as retire; then FETCH, or IDLE if run = 0.
  - JAL: PCWrite 1, PCSource 01, then WB.
  - JALR: ALUSrcA 01, ALUSrcB 10, PCWrite 1, PCSource 10, then WB.
  - LUI: then WB.
  - AUIPC: then WB (ALUOut already holds PC+imm).
- MEM:
  - Drive mem_req 1, IorD 1, and MemRead (load) or MemWrite (store).
  - On mem_ready: a load goes to WB; a store retires and goes to FETCH, or IDLE if run = 0.
- WB: RegWrite 1; WbSel is 01 for load, 10 for JAL/JALR, 11 for LUI, 00 otherwise. Retire, then FETCH, or IDLE if run = 0.
- Latency with zero-wait memory (cycles): branch 3; R/I/JAL/JALR/LUI/AUIPC 4; store 4; load 5.
- Wait counter:
  - Clears on entry to FETCH or MEM and increments each cycle mem_req = 1 and mem_ready = 0.
  - If TIMEOUT_CYCLES ≠ 0 and the counter equals TIMEOUT_CYCLES with mem_ready = 0, go to TRAP with cause 10.
  - mem_ready in that same cycle wins; no trap is taken.
- retire and instret:
  - retire is high for exactly one cycle per completed instruction.
  - instret increments with retire and wraps modulo 2**CNT_W.
  - Trapped instructions do not retire.
- TRAP: trap = 1, all memory/write enables 0, trap_cause held. trap_clear goes to IDLE and clears trap_cause.
- run is sampled only at instruction boundaries and in IDLE; deasserting it mid-instruction completes that instruction.
- Reset mid-access drops mem_req immediately (asynchronous).

Decomposition:
- Package rv_ctrl_pkg holds:
  - state encoding: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP;
  - the nine opcode constants;
  - ALUOp, PCSource, ALUSrcA/B and WbSel codes;
  - trap-cause codes.
- One combinational sub-module, rv_opcode_class, maps opcode to a one-hot class plus an illegal flag.

Test Plan:
- reset=1 then release, run=1, ADD (0110011), mem_ready always 1 -> states FETCH, DECODE, EXEC, WB; RegWrite high in cycle 4; retire pulse; instret = 1.
- LW (0000011), mem_ready delayed 3 cycles in MEM -> MEM held 4 cycles with mem_req=1, IorD=1, then WB with WbSel=01; total 8 cycles.
- BEQ with branch_taken=1, then BNE with branch_taken=0 -> PCWrite=1/PCSource=01 in EXEC for the first and PCWrite=0 for the second; 3 cycles each; instret +2.
- Opcode 1111111 -> TRAP after DECODE, trap_cause=01, no retire; trap_clear -> IDLE with trap_cause=00.
- TIMEOUT_CYCLES=4, mem_ready never asserted in FETCH -> TRAP with cause 10 at the 5th FETCH cycle; repeat with mem_ready on exactly that cycle -> no trap.
- reset asserted mid-MEM of a store -> mem_req and MemWrite drop asynchronously; state IDLE; instret=0.
